alu_share_arbiter: RTL and testbench

//   Shares the single 32-bit ALU between two requesters (e.g. main datapath and
//   an address/branch helper) using a valid/ready handshake.

---
 rtl/alu_share_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester round-robin front end for a shared 32-bit ALU
//
// Purpose:
//   Two requesters share one external combinational ALU. One transaction is in
//   flight at a time. Operands are latched on accept, and the ALU is driven from
//   those latches. The result and zero flag are registered one cycle later. They
//   are then held on the response channel, tagged with the requester id, until
//   the consumer takes them.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req0_* / req1_*             valid/ready request channels (op, a, b)
//   resp_valid/ready/id/        response channel: registered result, A==B flag,
//   resp_result/resp_zero       and issuing requester id
//   alu_op/alu_a/alu_b          operands to the external ALU (from latches)
//   alu_result/alu_zero         combinational ALU outputs
//   busy                        transaction in flight (state != IDLE)

module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_zero,

    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t              state;
    logic                rr_ptr;     // requester favoured when both are valid
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic                id_q;

    logic                grant0;
    logic                grant1;
    logic                accept;

    // Grants are only offered in IDLE and never while reset is asserted, so a
    // requester cannot believe it was accepted on a cycle the FSM discards.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && state == IDLE) begin
            grant0 = req0_valid && (!req1_valid || !rr_ptr);
            grant1 = req1_valid && (!req0_valid ||  rr_ptr);
        end
    end

    assign accept     = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // The ALU sees only latched operands; requesters may change their payload
    // freely once accepted.
    assign alu_op  = op_q;
    assign alu_a   = a_q;
    assign alu_b   = b_q;

    assign resp_id = id_q;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    if (accept) begin
                        op_q   <= grant1 ? req1_op : req0_op;
                        a_q    <= grant1 ? req1_a  : req0_a;
                        b_q    <= grant1 ? req1_b  : req0_b;
                        id_q   <= grant1;
                        // Hand priority to the requester that just lost.
                        rr_ptr <= ~grant1;
                        state  <= EXEC;
                    end
                end

                EXEC: begin
                    resp_result <= alu_result;
                    resp_zero   <= alu_zero;
                    resp_valid  <= 1'b1;
                    state       <= RESP;
                end

                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end

                // Unused encoding 2'b11 recovers to IDLE.
                default: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter

module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [2:0]  req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [2:0]  req1_op;
    logic [31:0] req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_id, resp_zero;
    logic [31:0] resp_result;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(32), .OP_W(3)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_zero(resp_zero),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy)
    );

    // External ALU stand-in
    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            3'b000:  alu_result = alu_a & alu_b;
            3'b001:  alu_result = alu_a | alu_b;
            3'b010:  alu_result = alu_a + alu_b;
            3'b011:  alu_result = alu_a - alu_b;
            3'b100:  alu_result = {alu_b[15:0], 16'h0};
            default: alu_result = 32'h0;
        endcase
        alu_zero = (alu_a == alu_b);
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits (sampling on falling edges) until resp_valid, at most 20 cycles.
    task automatic wait_resp(output int n);
        n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = 3'd2; req1_a = 32'd1; req1_b = 32'd1;
        resp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b resp_valid=%b expected 0 0", busy, resp_valid);
        end
        checks++;
        if (resp_result !== 32'h0 || resp_zero !== 1'b0 || resp_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: result=%h zero=%b id=%b expected 0 0 0", resp_result, resp_zero, resp_id);
        end
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: r0=%b r1=%b expected 0 0", req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd5; req0_b = 32'd7;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req0_a = 32'hDEAD;
        checks++;
        if (busy !== 1'b1 || resp_valid !== 1'b0 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
            errors++;
            $display("FAIL single_exec: busy=%b rv=%b alu_a=%h alu_b=%h expected 1 0 5 7", busy, resp_valid, alu_a, alu_b);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_result !== 32'd12 || resp_zero !== 1'b0 || resp_id !== 1'b0) begin
            errors++;
            $display("FAIL single_resp: rv=%b result=%h zero=%b id=%b expected 1 c 0 0", resp_valid, resp_result, resp_zero, resp_id);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: rv=%b busy=%b expected 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_both_valid();
        int n;
        do_reset();
        req0_valid = 1'b1; req0_op = 3'b011; req0_a = 32'd3; req0_b = 32'd3;
        req1_valid = 1'b1; req1_op = 3'b100; req1_a = 32'd0; req1_b = 32'h1234;
        resp_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL both_first_grant: r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        checks++;
        if (req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL both_no_grant_busy: r1=%b expected 0", req1_ready);
        end
        wait_resp(n);
        checks++;
        if (n >= 20 || resp_id !== 1'b0 || resp_result !== 32'h0 || resp_zero !== 1'b1) begin
            errors++;
            $display("FAIL both_resp0: waited=%0d id=%b result=%h zero=%b expected id 0 result 0 zero 1", n, resp_id, resp_result, resp_zero);
        end
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL both_second_grant: r1=%b expected 1", req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        wait_resp(n);
        checks++;
        if (n >= 20 || resp_id !== 1'b1 || resp_result !== 32'h12340000 || resp_zero !== 1'b0) begin
            errors++;
            $display("FAIL both_resp1: waited=%0d id=%b result=%h zero=%b expected id 1 result 12340000 zero 0", n, resp_id, resp_result, resp_zero);
        end
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        int acc_id[4];
        int acc_cyc[4];
        int n = 0;
        int c = 0;
        do_reset();
        req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd1;  req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = 3'b010; req1_a = 32'd10; req1_b = 32'd10;
        resp_ready = 1'b1;
        while (n < 4 && c < 40) begin
            #1;
            if (req0_ready === 1'b1) begin
                acc_id[n] = 0; acc_cyc[n] = c; n++;
            end else if (req1_ready === 1'b1) begin
                acc_id[n] = 1; acc_cyc[n] = c; n++;
            end
            if (n < 4) begin
                @(negedge clk);
                c++;
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL rr_count: accepts=%0d expected 4", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (acc_id[i] != (i % 2)) begin
                errors++;
                $display("FAIL rr_order[%0d]: id=%0d expected %0d", i, acc_id[i], i % 2);
            end
            if (i > 0) begin
                checks++;
                if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
                    errors++;
                    $display("FAIL rr_spacing[%0d]: gap=%0d expected 3", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain: busy=%b rv=%b expected 0 0", busy, resp_valid);
        end
        resp_ready = 1'b0;
    endtask

    task automatic test_stall();
        int n;
        do_reset();
        req1_valid = 1'b1; req1_op = 3'b000; req1_a = 32'hFF00FF00; req1_b = 32'h0FF00FF0;
        resp_ready = 1'b0;
        @(negedge clk);
        req1_valid = 1'b0;
        wait_resp(n);
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL stall_timeout: waited=%0d expected <20", n);
        end
        req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd9; req0_b = 32'd9;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_result !== 32'h0F000F00 || resp_id !== 1'b1 || resp_zero !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: rv=%b result=%h id=%b zero=%b expected 1 0f000f00 1 0", i, resp_valid, resp_result, resp_id, resp_zero);
            end
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready[%0d]: r0=%b r1=%b expected 0 0", i, req0_ready, req1_ready);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: rv=%b busy=%b expected 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_reset_in_exec();
        int n;
        do_reset();
        req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd1; req0_b = 32'd2;
        @(negedge clk);
        req0_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_result !== 32'h0) begin
            errors++;
            $display("FAIL exec_reset: rv=%b busy=%b result=%h expected 0 0 0", resp_valid, busy, resp_result);
        end
        req1_valid = 1'b1; req1_op = 3'b001; req1_a = 32'hF0; req1_b = 32'h0F;
        resp_ready = 1'b1;
        @(negedge clk);
        req1_valid = 1'b0;
        wait_resp(n);
        checks++;
        if (n >= 20 || resp_result !== 32'hFF || resp_id !== 1'b1 || resp_zero !== 1'b0) begin
            errors++;
            $display("FAIL exec_reset_next: waited=%0d result=%h id=%b zero=%b expected ff 1 0", n, resp_result, resp_id, resp_zero);
        end
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_bad_opcode();
        int n;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL badop_idle: busy=%b expected 0", busy);
        end
        req0_valid = 1'b1; req0_op = 3'b111; req0_a = 32'd1; req0_b = 32'd2;
        resp_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || alu_op !== 3'b111) begin
            errors++;
            $display("FAIL badop_exec: busy=%b alu_op=%b expected 1 111", busy, alu_op);
        end
        wait_resp(n);
        checks++;
        if (n >= 20 || resp_result !== 32'h0 || resp_zero !== 1'b0) begin
            errors++;
            $display("FAIL badop_resp: waited=%0d result=%h zero=%b expected 0 0", n, resp_result, resp_zero);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL badop_busy_hold: busy=%b expected 1", busy);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL badop_done: busy=%b rv=%b expected 0 0", busy, resp_valid);
        end
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        resp_ready = 1'b0;
        test_reset();
        test_single();
        test_both_valid();
        test_round_robin();
        test_stall();
        test_reset_in_exec();
        test_bad_opcode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
